// File: rtl/execute_m.sv
// RV32 execute stage: RV32I ALU, branch resolution with redirect to fetch,
// and an optional iterative RV32M unit that stalls the valid/ready handshake while busy.
module execute_m #(
  parameter int XLEN     = 32,
  parameter int ENABLE_M = 1,
  parameter int MUL_FAST = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            valid_i,
  output logic            ready_o,
  output logic            valid_ro,
  input  logic            ready_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] inst_i,
  input  logic [XLEN-1:0] r0data_i,
  input  logic [XLEN-1:0] r1data_i,
  output logic [XLEN-1:0] pc_ro,
  output logic [XLEN-1:0] inst_ro,
  output logic [XLEN-1:0] r0data_ro,
  output logic [XLEN-1:0] r1data_ro,
  output logic [XLEN-1:0] result_ro,
  output logic [XLEN-1:0] jump_addr_o,
  output logic            jump_taken_o
);
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t      state_r, state_nx;
  logic [6:0]  opcode_s;
  logic [2:0]  funct3_s;
  logic [31:0] imm_i_s, imm_st_s, imm_b_s, imm_u_s, imm_j_s;
  logic        is_op_s, is_mext_s, is_m_s, cke_s, accept_s, start_s, br_cond_s;
  logic [31:0] op_b_s, alu_s, sra_s, result_s, jaddr_s;
  logic [4:0]  shamt_s;
  logic        sa_s, sb_s, fsa_s, fsb_s;
  logic [63:0] fast_prod_s;
  logic [31:0] fast_res_s;
  logic [4:0]  cnt_r;
  logic [63:0] prod_r, step_s, signed_prod_s;
  logic [31:0] opb_r, quo_s, rem_s, m_res_s;
  logic [2:0]  f3_r;
  logic        neg_r, sa_r, bzero_r;
  logic [32:0] mul_sum_s, div_trial_s;

  assign opcode_s = inst_i[6:0];
  assign funct3_s = inst_i[14:12];
  assign imm_i_s  = {{20{inst_i[31]}}, inst_i[31:20]};
  assign imm_st_s = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign imm_b_s  = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_u_s  = {inst_i[31:12], 12'd0};
  assign imm_j_s  = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

  assign is_op_s   = (opcode_s == OPC_OP);
  assign is_mext_s = is_op_s && (inst_i[31:25] == 7'b0000001);
  assign is_m_s    = is_mext_s && (ENABLE_M != 0) && !((MUL_FAST != 0) && !funct3_s[2]);

  assign cke_s    = ~valid_ro | ready_i;
  assign ready_o  = cke_s & (~(valid_i & is_m_s) | (state_r == DONE));
  assign accept_s = valid_i & ready_o & ~flush_i;
  assign start_s  = (state_r == IDLE) & valid_i & is_m_s & cke_s & ~flush_i;

  assign op_b_s  = is_op_s ? r1data_i : imm_i_s;
  assign shamt_s = op_b_s[4:0];
  assign sra_s   = $signed(r0data_i) >>> shamt_s;

  // Base integer ALU shared by OP and OP-IMM
  always_comb begin
    alu_s = 32'd0;
    case (funct3_s)
      3'b000: if (is_op_s && inst_i[30]) alu_s = r0data_i - op_b_s; else alu_s = r0data_i + op_b_s;
      3'b001: alu_s = r0data_i << shamt_s;
      3'b010: alu_s = {31'd0, $signed(r0data_i) < $signed(op_b_s)};
      3'b011: alu_s = {31'd0, r0data_i < op_b_s};
      3'b100: alu_s = r0data_i ^ op_b_s;
      3'b101: if (inst_i[30]) alu_s = sra_s; else alu_s = r0data_i >> shamt_s;
      3'b110: alu_s = r0data_i | op_b_s;
      3'b111: alu_s = r0data_i & op_b_s;
      default: alu_s = 32'hFFFF_FFFF;
    endcase
  end

  // Branch condition evaluation
  always_comb begin
    br_cond_s = 1'b0;
    case (funct3_s)
      3'b000: br_cond_s = (r0data_i == r1data_i);
      3'b001: br_cond_s = (r0data_i != r1data_i);
      3'b100: br_cond_s = ($signed(r0data_i) < $signed(r1data_i));
      3'b101: br_cond_s = ($signed(r0data_i) >= $signed(r1data_i));
      3'b110: br_cond_s = (r0data_i < r1data_i);
      3'b111: br_cond_s = (r0data_i >= r1data_i);
      default: br_cond_s = 1'b0;
    endcase
  end

  // Sign-extend each operand according to its signedness, then one 64-bit multiply
  assign fsa_s       = r0data_i[31] & ((funct3_s == 3'b001) || (funct3_s == 3'b010));
  assign fsb_s       = r1data_i[31] & (funct3_s == 3'b001);
  assign fast_prod_s = {{32{fsa_s}}, r0data_i} * {{32{fsb_s}}, r1data_i};
  assign fast_res_s  = (funct3_s == 3'b000) ? fast_prod_s[31:0] : fast_prod_s[63:32];

  // Iterative unit works on magnitudes; signs are reapplied once DONE
  assign sa_s = r0data_i[31] & ((funct3_s == 3'b001) || (funct3_s == 3'b010) ||
                                (funct3_s == 3'b100) || (funct3_s == 3'b110));
  assign sb_s = r1data_i[31] & ((funct3_s == 3'b001) || (funct3_s == 3'b100) || (funct3_s == 3'b110));

  assign mul_sum_s   = {1'b0, prod_r[63:32]} + (prod_r[0] ? {1'b0, opb_r} : 33'd0);
  assign div_trial_s = prod_r[63:31] - {1'b0, opb_r};

  // One radix-2 step: shift-add multiply or restoring divide
  always_comb begin
    step_s = prod_r;
    if (f3_r[2]) begin
      if (!div_trial_s[32]) step_s = {div_trial_s[31:0], prod_r[30:0], 1'b1};
      else                  step_s = {prod_r[62:0], 1'b0};
    end else begin
      step_s = {mul_sum_s, prod_r[31:1]};
    end
  end

  assign signed_prod_s = neg_r ? (64'd0 - prod_r) : prod_r;
  assign quo_s   = (neg_r & ~bzero_r) ? (32'd0 - prod_r[31:0]) : prod_r[31:0];
  assign rem_s   = sa_r ? (32'd0 - prod_r[63:32]) : prod_r[63:32];
  assign m_res_s = !f3_r[2] ? ((f3_r[1:0] == 2'b00) ? signed_prod_s[31:0] : signed_prod_s[63:32])
                            : (f3_r[1] ? rem_s : quo_s);

  // Result and redirect-target selection by opcode
  always_comb begin
    result_s = 32'hFFFF_FFFF;
    jaddr_s  = 32'hFFFF_FFFF;
    case (opcode_s)
      OPC_LUI:    result_s = imm_u_s;
      OPC_AUIPC:  result_s = pc_i + imm_u_s;
      OPC_JAL:    begin result_s = pc_i + 32'd4; jaddr_s = pc_i + imm_j_s; end
      OPC_JALR:   begin result_s = pc_i + 32'd4; jaddr_s = (r0data_i + imm_i_s) & 32'hFFFF_FFFE; end
      OPC_BRANCH: begin result_s = 32'd0; jaddr_s = pc_i + imm_b_s; end
      OPC_LOAD:   result_s = r0data_i + imm_i_s;
      OPC_STORE:  result_s = r0data_i + imm_st_s;
      OPC_OPIMM:  result_s = alu_s;
      OPC_OP: begin
        if (!is_mext_s)                           result_s = alu_s;
        else if (ENABLE_M == 0)                   result_s = 32'hFFFF_FFFF;
        else if ((MUL_FAST != 0) && !funct3_s[2]) result_s = fast_res_s;
        else                                      result_s = m_res_s;
      end
      default:    result_s = 32'hFFFF_FFFF;
    endcase
  end

  assign jump_addr_o  = jaddr_s;
  assign jump_taken_o = ((opcode_s == OPC_JAL) | (opcode_s == OPC_JALR) |
                         ((opcode_s == OPC_BRANCH) & br_cond_s)) & accept_s;

  // M-unit state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nx;
  end

  // M-unit next-state logic; flush always wins
  always_comb begin
    state_nx = state_r;
    if (flush_i) begin
      state_nx = IDLE;
    end else begin
      case (state_r)
        IDLE:    if (start_s) state_nx = BUSY; else state_nx = IDLE;
        BUSY:    if (cnt_r == 5'd0) state_nx = DONE; else state_nx = BUSY;
        DONE:    if (accept_s) state_nx = IDLE; else state_nx = DONE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // M-unit operand latch and iteration datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r   <= 5'd0;
      prod_r  <= 64'd0;
      opb_r   <= 32'd0;
      f3_r    <= 3'd0;
      neg_r   <= 1'b0;
      sa_r    <= 1'b0;
      bzero_r <= 1'b0;
    end else if (start_s) begin
      cnt_r   <= 5'd31;
      prod_r  <= {32'd0, sa_s ? (32'd0 - r0data_i) : r0data_i};
      opb_r   <= sb_s ? (32'd0 - r1data_i) : r1data_i;
      f3_r    <= funct3_s;
      neg_r   <= sa_s ^ sb_s;
      sa_r    <= sa_s;
      bzero_r <= (r1data_i == 32'd0);
    end else if ((state_r == BUSY) && !flush_i) begin
      prod_r <= step_s;
      if (cnt_r != 5'd0) cnt_r <= cnt_r - 5'd1;
    end
  end

  // Downstream output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_ro  <= 1'b0;
      pc_ro     <= 32'd0;
      inst_ro   <= 32'd0;
      r0data_ro <= 32'd0;
      r1data_ro <= 32'd0;
      result_ro <= 32'd0;
    end else if (flush_i) begin
      valid_ro <= 1'b0;
    end else if (accept_s) begin
      valid_ro  <= 1'b1;
      pc_ro     <= pc_i;
      inst_ro   <= inst_i;
      r0data_ro <= r0data_i;
      r1data_ro <= r1data_i;
      result_ro <= result_s;
    end else if (cke_s) begin
      valid_ro <= 1'b0;
    end
  end
endmodule

// File: tb/tb_execute_m.sv
// Randomized self-checking bench for execute_m against an arithmetic reference model,
// plus directed checks for latency, backpressure, flush and reset.
module tb_execute_m;
  logic        clk = 1'b0;
  logic        rst, flush_i, valid_i, ready_o, valid_ro, ready_i, jump_taken_o;
  logic [31:0] pc_i, inst_i, r0data_i, r1data_i;
  logic [31:0] pc_ro, inst_ro, r0data_ro, r1data_ro, result_ro, jump_addr_o;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [6:0] OP = 7'b0110011;

  execute_m dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .valid_ro(valid_ro), .ready_i(ready_i), .pc_i(pc_i), .inst_i(inst_i),
    .r0data_i(r0data_i), .r1data_i(r1data_i), .pc_ro(pc_ro), .inst_ro(inst_ro),
    .r0data_ro(r0data_ro), .r1data_ro(r1data_ro), .result_ro(result_ro),
    .jump_addr_o(jump_addr_o), .jump_taken_o(jump_taken_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference model: architectural result, redirect target/strobe, and whether the op is iterative
  function automatic void model(input logic [31:0] pc, inst, a, b,
                                output logic [31:0] res, output logic [31:0] jaddr,
                                output logic jt, output bit m_iter);
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, opb;
    logic [63:0] p;
    int          sa, sb, sopb, sh;
    longint      la, lb;
    opc = inst[6:0]; f3 = inst[14:12];
    imm_i = {{20{inst[31]}}, inst[31:20]};
    imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    imm_u = {inst[31:12], 12'd0};
    imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    sa = a; sb = b;
    opb = (opc == OP) ? b : imm_i;
    sopb = opb; sh = opb[4:0];
    res = 32'hFFFF_FFFF; jaddr = 32'hFFFF_FFFF; jt = 1'b0; m_iter = 1'b0;
    if (opc == OP && inst[31:25] == 7'b0000001) begin
      m_iter = 1'b1;
      case (f3)
        3'd0: begin la = sa; lb = sb; p = la * lb; res = p[31:0]; end
        3'd1: begin la = sa; lb = sb; p = la * lb; res = p[63:32]; end
        3'd2: begin la = sa; lb = {32'd0, b}; p = la * lb; res = p[63:32]; end
        3'd3: begin p = {32'd0, a} * {32'd0, b}; res = p[63:32]; end
        3'd4: if (b == 0) res = 32'hFFFF_FFFF;
              else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = 32'h8000_0000;
              else res = sa / sb;
        3'd5: if (b == 0) res = 32'hFFFF_FFFF; else res = a / b;
        3'd6: if (b == 0) res = a;
              else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = 32'd0;
              else res = sa % sb;
        default: if (b == 0) res = a; else res = a % b;
      endcase
    end else begin
      case (opc)
        7'b0010011, OP: case (f3)
          3'd0: res = (opc == OP && inst[30]) ? a - opb : a + opb;
          3'd1: res = a << sh;
          3'd2: res = (sa < sopb) ? 32'd1 : 32'd0;
          3'd3: res = (a < opb) ? 32'd1 : 32'd0;
          3'd4: res = a ^ opb;
          3'd5: if (inst[30]) res = sa >>> sh; else res = a >> sh;
          3'd6: res = a | opb;
          default: res = a & opb;
        endcase
        7'b0110111: res = imm_u;
        7'b0010111: res = pc + imm_u;
        7'b1101111: begin res = pc + 32'd4; jaddr = pc + imm_j; jt = 1'b1; end
        7'b1100111: begin res = pc + 32'd4; jaddr = (a + imm_i) & 32'hFFFF_FFFE; jt = 1'b1; end
        7'b1100011: begin
          res = 32'd0; jaddr = pc + imm_b;
          case (f3)
            3'd0: jt = (a == b);
            3'd1: jt = (a != b);
            3'd4: jt = (sa < sb);
            3'd5: jt = (sa >= sb);
            3'd6: jt = (a < b);
            3'd7: jt = (a >= b);
            default: jt = 1'b0;
          endcase
        end
        7'b0000011: res = a + imm_i;
        7'b0100011: res = a + imm_s;
        default: res = 32'hFFFF_FFFF;
      endcase
    end
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd3, OP};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [2:0] f3);
    return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] base;
    base = $urandom();
    case ($urandom_range(0, 12))
      0, 1:    return {base[31:7], 7'b0010011};
      2:       return {1'b0, base[30], 5'd0, base[24:7], OP};
      3, 4:    return {7'b0000001, base[24:7], OP};
      5:       return {base[31:7], 7'b0110111};
      6:       return {base[31:7], 7'b0010111};
      7:       return {base[31:7], 7'b1101111};
      8:       return {base[31:7], 7'b1100111};
      9:       return {base[31:7], 7'b1100011};
      10:      return {base[31:7], 7'b0000011};
      11:      return {base[31:7], 7'b0100011};
      default: return {base[31:7], 7'b1110011};
    endcase
  endfunction

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return $urandom_range(0, 20);
      default: return $urandom();
    endcase
  endfunction

  // Present one instruction, wait (bounded) for acceptance, then check the loaded outputs
  task automatic run_txn(input logic [31:0] pc, inst, a, b,
                         output logic jt_seen, output logic [31:0] ja_seen, output int lat);
    logic [31:0] er, ea;
    logic        et;
    bit          em;
    model(pc, inst, a, b, er, ea, et, em);
    @(negedge clk);
    pc_i = pc; inst_i = inst; r0data_i = a; r1data_i = b; valid_i = 1'b1;
    lat = 0;
    #1;
    while (!ready_o && lat < 200) begin
      @(negedge clk); #1; lat++;
    end
    jt_seen = jump_taken_o; ja_seen = jump_addr_o;
    if (!ready_o) begin
      check_eq("accept_timeout", {31'd0, ready_o}, 32'd1);
      valid_i = 1'b0;
    end else begin
      check_eq("latency", lat, em ? 32'd33 : 32'd0);
      check_eq("jump_taken", {31'd0, jump_taken_o}, {31'd0, et});
      check_eq("jump_addr", jump_addr_o, ea);
      @(posedge clk); #1;
      valid_i = 1'b0;
      check_eq("valid_ro", {31'd0, valid_ro}, 32'd1);
      check_eq("result_ro", result_ro, er);
      check_eq("pc_ro", pc_ro, pc);
      check_eq("inst_ro", inst_ro, inst);
      check_eq("r0data_ro", r0data_ro, a);
      check_eq("r1data_ro", r1data_ro, b);
    end
  endtask

  logic        tjt;
  logic [31:0] tja, er, ea, held;
  logic        et;
  bit          em;
  int          tlat;

  initial begin
    rst = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    pc_i = 32'd0; inst_i = 32'd0; r0data_i = 32'd0; r1data_i = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", {31'd0, valid_ro}, 32'd0);
    check_eq("rst_result", result_ro, 32'd0);
    check_eq("rst_pc", pc_ro, 32'd0);
    @(negedge clk); rst = 1'b0;

    run_txn(32'h40, enc_r(7'b0000000, 3'b000), 32'd5, 32'hFFFF_FFFD, tjt, tja, tlat);
    check_eq("tp_add", result_ro, 32'd2);
    run_txn(32'h44, enc_r(7'b0100000, 3'b000), 32'd5, 32'hFFFF_FFFD, tjt, tja, tlat);
    check_eq("tp_sub", result_ro, 32'd8);
    run_txn(32'h48, enc_r(7'b0100000, 3'b101), 32'h8000_0000, 32'd4, tjt, tja, tlat);
    check_eq("tp_sra", result_ro, 32'hF800_0000);
    run_txn(32'h100, enc_b(13'h1FF0, 3'b100), 32'hFFFF_FFFF, 32'd1, tjt, tja, tlat);
    check_eq("tp_blt_taken", {31'd0, tjt}, 32'd1);
    check_eq("tp_blt_addr", tja, 32'h0000_00F0);
    run_txn(32'h100, enc_b(13'h1FF0, 3'b110), 32'hFFFF_FFFF, 32'd1, tjt, tja, tlat);
    check_eq("tp_bltu_taken", {31'd0, tjt}, 32'd0);

    run_txn(32'h200, enc_r(7'b0000001, 3'b001), 32'h8000_0000, 32'h8000_0000, tjt, tja, tlat);
    check_eq("tp_mulh", result_ro, 32'h4000_0000);
    check_eq("tp_mulh_lat", tlat, 32'd33);
    run_txn(32'h204, enc_r(7'b0000001, 3'b010), 32'hFFFF_FFFF, 32'hFFFF_FFFF, tjt, tja, tlat);
    check_eq("tp_mulhsu", result_ro, 32'hFFFF_FFFF);
    run_txn(32'h208, enc_r(7'b0000001, 3'b100), 32'd7, 32'd0, tjt, tja, tlat);
    check_eq("tp_div0", result_ro, 32'hFFFF_FFFF);
    run_txn(32'h20C, enc_r(7'b0000001, 3'b110), 32'd7, 32'd0, tjt, tja, tlat);
    check_eq("tp_rem0", result_ro, 32'd7);
    run_txn(32'h210, enc_r(7'b0000001, 3'b100), 32'h8000_0000, 32'hFFFF_FFFF, tjt, tja, tlat);
    check_eq("tp_div_ovf", result_ro, 32'h8000_0000);
    run_txn(32'h214, enc_r(7'b0000001, 3'b110), 32'hFFFF_FFF9, 32'd2, tjt, tja, tlat);
    check_eq("tp_rem_neg", result_ro, 32'hFFFF_FFFF);

    // Backpressure: a loaded result holds while ready_i is low
    run_txn(32'h300, enc_r(7'b0000000, 3'b000), 32'd10, 32'd20, tjt, tja, tlat);
    held = result_ro;
    @(negedge clk);
    ready_i = 1'b0;
    pc_i = 32'h304; inst_i = enc_r(7'b0000000, 3'b000); r0data_i = 32'd1; r1data_i = 32'd2; valid_i = 1'b1;
    model(pc_i, inst_i, r0data_i, r1data_i, er, ea, et, em);
    for (int i = 0; i < 2; i++) begin
      #1 check_eq("bp_ready_o", {31'd0, ready_o}, 32'd0);
      @(posedge clk); #1;
      check_eq("bp_hold_result", result_ro, held);
      check_eq("bp_hold_valid", {31'd0, valid_ro}, 32'd1);
      @(negedge clk);
    end
    ready_i = 1'b1;
    #1 check_eq("bp_release_ready", {31'd0, ready_o}, 32'd1);
    @(posedge clk); #1;
    check_eq("bp_release_result", result_ro, er);
    valid_i = 1'b0;
    @(posedge clk); #1;
    check_eq("bp_drain", {31'd0, valid_ro}, 32'd0);
    ready_i = 1'b0;
    run_txn(32'h308, enc_r(7'b0000001, 3'b011), 32'hFFFF_FFFF, 32'd3, tjt, tja, tlat);
    @(negedge clk); #1;
    check_eq("bp_m_ready_o", {31'd0, ready_o}, 32'd0);
    @(posedge clk); #1;
    check_eq("bp_m_hold", {31'd0, valid_ro}, 32'd1);
    ready_i = 1'b1;

    // Streaming: back-to-back ADDI every cycle
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pc_i = 32'h400 + 32'(i * 4); inst_i = {12'(i * 3 + 1), 5'd1, 3'b000, 5'd3, 7'b0010011};
      r0data_i = $urandom(); r1data_i = $urandom(); valid_i = 1'b1;
      model(pc_i, inst_i, r0data_i, r1data_i, er, ea, et, em);
      #1 check_eq("stream_ready", {31'd0, ready_o}, 32'd1);
      @(posedge clk); #1;
      check_eq("stream_result", result_ro, er);
      check_eq("stream_valid", {31'd0, valid_ro}, 32'd1);
    end
    valid_i = 1'b0;

    // Flush during BUSY iteration 10
    run_txn(32'h500, enc_r(7'b0000000, 3'b000), 32'd3, 32'd4, tjt, tja, tlat);
    @(negedge clk);
    pc_i = 32'h504; inst_i = enc_r(7'b0000001, 3'b101); r0data_i = 32'd1000; r1data_i = 32'd7; valid_i = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk); #1;
    check_eq("busy_ready_o", {31'd0, ready_o}, 32'd0);
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0; valid_i = 1'b0;
    check_eq("flush_valid", {31'd0, valid_ro}, 32'd0);
    check_eq("flush_hold_pc", pc_ro, 32'h500);
    run_txn(32'h508, enc_r(7'b0000000, 3'b000), 32'd9, 32'd1, tjt, tja, tlat);
    run_txn(32'h50C, enc_r(7'b0000001, 3'b101), 32'd1000, 32'd7, tjt, tja, tlat);

    // Flush kills a JAL: no redirect and nothing loaded
    @(negedge clk);
    pc_i = 32'h600; inst_i = {20'h00010, 5'd1, 7'b1101111}; valid_i = 1'b1; flush_i = 1'b1;
    #1 check_eq("flush_jump", {31'd0, jump_taken_o}, 32'd0);
    @(posedge clk); #1;
    check_eq("flush_jal_valid", {31'd0, valid_ro}, 32'd0);
    flush_i = 1'b0; valid_i = 1'b0;

    // Async reset during BUSY
    run_txn(32'h700, enc_r(7'b0000000, 3'b000), 32'd3, 32'd4, tjt, tja, tlat);
    @(negedge clk);
    pc_i = 32'h704; inst_i = enc_r(7'b0000001, 3'b000); r0data_i = 32'd123; r1data_i = 32'd456; valid_i = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check_eq("arst_valid", {31'd0, valid_ro}, 32'd0);
    check_eq("arst_pc", pc_ro, 32'd0);
    check_eq("arst_inst", inst_ro, 32'd0);
    check_eq("arst_r0", r0data_ro, 32'd0);
    check_eq("arst_r1", r1data_ro, 32'd0);
    check_eq("arst_result", result_ro, 32'd0);
    valid_i = 1'b0;
    @(negedge clk); rst = 1'b0;
    run_txn(32'h708, enc_r(7'b0000001, 3'b000), 32'd123, 32'd456, tjt, tja, tlat);

    // Randomized traffic against the reference model
    for (int i = 0; i < 120; i++) begin
      run_txn($urandom() & 32'hFFFF_FFFC, rand_inst(), rand_op(), rand_op(), tjt, tja, tlat);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
